// File: rtl/spart_pkg.sv
// Shared state encoding and baud divisor constants for the SPART configuration sequencer.
// Divisors assume a 100 MHz clock with 16x oversampling.
package spart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    LOAD_HI,
    LOAD_LO,
    SETTLE,
    DONE
  } cfg_state_t;

  localparam logic [1:0] DEFAULT_SEL_C = 2'b01;

  // Entry 0 is the rightmost constant: 0=4800, 1=9600, 2=19200, 3=38400 baud.
  localparam logic [3:0][15:0] DIV_TABLE = {16'h00A3, 16'h0145, 16'h028B, 16'h0516};

  function automatic logic [15:0] div_lookup(input logic [1:0] sel);
    return DIV_TABLE[sel];
  endfunction

endpackage

// File: rtl/brg_cfg_timer.sv
// Loadable saturating down-counter with a zero flag, shared by the settle wait and drain timeout.
module brg_cfg_timer #(
  parameter int                WIDTH     = 16,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  // Load has priority; counting stops at zero so the flag holds until reloaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= RESET_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/brg_cfg_seq.sv
// Baud-rate divisor load sequencer: drains the transmitter, then writes DBH and DBL in order.
// Optional drain timeout with sticky cfg_err is enabled by defining BRG_DRAIN_TIMEOUT_EN.
module brg_cfg_seq
  import spart_pkg::*;
#(
  parameter int         SETTLE_CYC  = 4,
  parameter logic [1:0] DEFAULT_SEL = DEFAULT_SEL_C,
  parameter int         DRAIN_MAX   = 65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_req,
  input  logic [1:0] cfg_sel,
  input  logic       tx_busy,
  output logic       tx_hold,
  output logic       brg_load_high,
  output logic       brg_load_low,
  output logic [7:0] brg_data,
  output logic       cfg_busy,
  output logic       cfg_ack,
  output logic       brg_valid,
`ifdef BRG_DRAIN_TIMEOUT_EN
  output logic       cfg_err,
`endif
  output logic [1:0] cur_sel
);

  localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYC - 1);
  localparam logic [15:0] DRAIN_LOAD  = 16'(DRAIN_MAX - 1);

  cfg_state_t  state;
  logic [1:0]  pend_sel;
  logic [1:0]  seq_sel;
  logic        pend_flag;
  logic [15:0] div_word;

  logic        timer_load;
  logic        timer_en;
  logic [15:0] timer_val;
  logic        timer_zero;

  // Reset lands in DRAIN so the timer must already hold the drain budget.
  brg_cfg_timer #(
    .WIDTH     (16),
    .RESET_VAL (DRAIN_LOAD)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .en       (timer_en),
    .load_val (timer_val),
    .zero     (timer_zero)
  );

  always_comb begin
    timer_load = 1'b0;
    timer_en   = 1'b0;
    timer_val  = SETTLE_LOAD;
    case (state)
      LOAD_LO: timer_load = 1'b1;
      SETTLE:  timer_en   = 1'b1;
`ifdef BRG_DRAIN_TIMEOUT_EN
      IDLE, DONE: begin
        timer_load = 1'b1;
        timer_val  = DRAIN_LOAD;
      end
      DRAIN:   timer_en   = tx_busy;
`endif
      default: ;
    endcase
  end

  // seq_sel is frozen at DRAIN entry; later requests only touch pend_sel/pend_flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= DRAIN;
      pend_sel  <= DEFAULT_SEL;
      seq_sel   <= DEFAULT_SEL;
      pend_flag <= 1'b0;
      cur_sel   <= DEFAULT_SEL;
      brg_valid <= 1'b0;
`ifdef BRG_DRAIN_TIMEOUT_EN
      cfg_err   <= 1'b0;
`endif
    end else begin
      if (cfg_req && (state != IDLE) && (state != DONE)) begin
        pend_flag <= 1'b1;
        pend_sel  <= cfg_sel;
      end
      case (state)
        IDLE: begin
          if (cfg_req) begin
            pend_sel <= cfg_sel;
            seq_sel  <= cfg_sel;
            state    <= DRAIN;
          end
        end
        DRAIN: begin
          if (!tx_busy) begin
            state <= LOAD_HI;
          end
`ifdef BRG_DRAIN_TIMEOUT_EN
          else if (timer_zero) begin
            state   <= LOAD_HI;
            cfg_err <= 1'b1;
          end
`endif
        end
        LOAD_HI: state <= LOAD_LO;
        LOAD_LO: state <= SETTLE;
        SETTLE: begin
          if (timer_zero) begin
            state <= DONE;
          end
        end
        DONE: begin
          cur_sel   <= seq_sel;
          brg_valid <= 1'b1;
          if (cfg_req) begin
            pend_sel  <= cfg_sel;
            seq_sel   <= cfg_sel;
            pend_flag <= 1'b0;
            state     <= DRAIN;
          end else if (pend_flag) begin
            seq_sel   <= pend_sel;
            pend_flag <= 1'b0;
            state     <= DRAIN;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign div_word      = div_lookup(seq_sel);
  assign tx_hold       = (state != IDLE);
  assign cfg_busy      = (state != IDLE);
  assign cfg_ack       = (state == DONE);
  assign brg_load_high = (state == LOAD_HI);
  assign brg_load_low  = (state == LOAD_LO);
  assign brg_data      = (state == LOAD_HI) ? div_word[15:8] :
                         (state == LOAD_LO) ? div_word[7:0]  : 8'h00;

endmodule

// File: tb/tb_brg_cfg_seq.sv
// Scoreboard bench for brg_cfg_seq: expected strobe/ack events are queued as stimulus is driven.
// Define BRG_DRAIN_TIMEOUT_EN to also exercise the drain timeout with DRAIN_MAX=16.
module tb_brg_cfg_seq;

  localparam int SETTLE_CYC = 4;
`ifdef BRG_DRAIN_TIMEOUT_EN
  localparam int DRAIN_MAX = 16;
  localparam int BUSY_CYC  = 10;
`else
  localparam int DRAIN_MAX = 65535;
  localparam int BUSY_CYC  = 20;
`endif

  typedef enum logic [1:0] {EV_HI, EV_LO, EV_ACK} ev_kind_t;
  typedef struct packed {
    ev_kind_t   kind;
    logic [7:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_req;
  logic [1:0] cfg_sel;
  logic       tx_busy;
  logic       tx_hold;
  logic       brg_load_high;
  logic       brg_load_low;
  logic [7:0] brg_data;
  logic       cfg_busy;
  logic       cfg_ack;
  logic       brg_valid;
  logic [1:0] cur_sel;
`ifdef BRG_DRAIN_TIMEOUT_EN
  logic       cfg_err;
`endif

  ev_t exp_q[$];
  int  errors    = 0;
  int  checks    = 0;
  int  ack_count = 0;

  always #5 clk = ~clk;

  brg_cfg_seq #(
    .SETTLE_CYC  (SETTLE_CYC),
    .DEFAULT_SEL (2'b01),
    .DRAIN_MAX   (DRAIN_MAX)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_req       (cfg_req),
    .cfg_sel       (cfg_sel),
    .tx_busy       (tx_busy),
    .tx_hold       (tx_hold),
    .brg_load_high (brg_load_high),
    .brg_load_low  (brg_load_low),
    .brg_data      (brg_data),
    .cfg_busy      (cfg_busy),
    .cfg_ack       (cfg_ack),
    .brg_valid     (brg_valid),
`ifdef BRG_DRAIN_TIMEOUT_EN
    .cfg_err       (cfg_err),
`endif
    .cur_sel       (cur_sel)
  );

  // Independent divisor reference: 100 MHz / (16 * baud).
  function automatic logic [15:0] tb_div(input logic [1:0] sel);
    case (sel)
      2'd0:    return 16'h0516;
      2'd1:    return 16'h028B;
      2'd2:    return 16'h0145;
      default: return 16'h00A3;
    endcase
  endfunction

  task automatic push_hi_lo(input logic [15:0] div);
    exp_q.push_back('{kind: EV_HI, data: div[15:8]});
    exp_q.push_back('{kind: EV_LO, data: div[7:0]});
  endtask

  task automatic push_seq(input logic [15:0] div);
    push_hi_lo(div);
    exp_q.push_back('{kind: EV_ACK, data: 8'h00});
  endtask

  // Steps whole cycles until cfg_ack is seen at a falling edge or the budget runs out.
  task automatic wait_ack(input int limit, output int n);
    n = 0;
    forever begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (cfg_ack === 1'b1 || n >= limit) break;
    end
  endtask

  // Scoreboard: every strobe or ack pops the oldest expected event.
  always @(negedge clk) begin
    ev_t      e;
    ev_kind_t k;
    if (rst === 1'b0) begin
      if (brg_load_high === 1'b1 && brg_load_low === 1'b1) begin
        errors++;
        $display("[TB] FAIL strobe_overlap: high=%b low=%b required not both", brg_load_high, brg_load_low);
      end
      if (brg_load_high === 1'b1 || brg_load_low === 1'b1 || cfg_ack === 1'b1) begin
        k = brg_load_high ? EV_HI : (brg_load_low ? EV_LO : EV_ACK);
        if (cfg_ack === 1'b1) ack_count++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_event: got kind=%0d data=%02h required no event", k, brg_data);
        end else begin
          e = exp_q.pop_front();
          if (e.kind !== k || e.data !== brg_data) begin
            errors++;
            $display("[TB] FAIL event: got kind=%0d data=%02h required kind=%0d data=%02h",
                     k, brg_data, e.kind, e.data);
          end
        end
      end else if (brg_data !== 8'h00) begin
        errors++;
        $display("[TB] FAIL idle_data: got %02h required 00", brg_data);
      end
    end
  end

  task automatic test_reset();
    int n;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (tx_hold !== 1'b1 || cfg_busy !== 1'b1 || brg_load_high !== 1'b0 || brg_load_low !== 1'b0 ||
        brg_data !== 8'h00 || cfg_ack !== 1'b0 || brg_valid !== 1'b0 || cur_sel !== 2'd1) begin
      errors++;
      $display("[TB] FAIL reset_state: hold=%b busy=%b hi=%b lo=%b data=%02h ack=%b valid=%b sel=%0d required 1 1 0 0 00 0 0 1",
               tx_hold, cfg_busy, brg_load_high, brg_load_low, brg_data, cfg_ack, brg_valid, cur_sel);
    end
`ifdef BRG_DRAIN_TIMEOUT_EN
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_err: got %b required 0", cfg_err);
    end
`endif
    push_seq(tb_div(2'd1));
    rst = 1'b0;
    wait_ack(40, n);
    // Reset enters DRAIN directly, so the IDLE accept cycle of a normal request is absent.
    checks++;
    if (cfg_ack !== 1'b1 || n != 3 + SETTLE_CYC) begin
      errors++;
      $display("[TB] FAIL reset_ack_latency: ack=%b cycles=%0d required ack=1 cycles=%0d", cfg_ack, n, 3 + SETTLE_CYC);
    end
    checks++;
    if (brg_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL valid_before_done: got %b required 0", brg_valid);
    end
    @(negedge clk);
    checks++;
    if (brg_valid !== 1'b1 || cur_sel !== 2'd1 || cfg_busy !== 1'b0 || tx_hold !== 1'b0) begin
      errors++;
      $display("[TB] FAIL post_default: valid=%b sel=%0d busy=%b hold=%b required 1 1 0 0",
               brg_valid, cur_sel, cfg_busy, tx_hold);
    end
  endtask

  task automatic test_sel3();
    int n;
    bit hold_ok;
    cfg_req = 1'b1;
    cfg_sel = 2'd3;
    push_seq(tb_div(2'd3));
    n = 0;
    hold_ok = 1'b1;
    forever begin
      @(posedge clk);
      n++;
      @(negedge clk);
      cfg_req = 1'b0;
      if (tx_hold !== 1'b1) hold_ok = 1'b0;
      if (cfg_ack === 1'b1 || n >= 40) break;
    end
    checks++;
    if (cfg_ack !== 1'b1 || n != 4 + SETTLE_CYC) begin
      errors++;
      $display("[TB] FAIL sel3_latency: ack=%b cycles=%0d required ack=1 cycles=%0d", cfg_ack, n, 4 + SETTLE_CYC);
    end
    checks++;
    if (!hold_ok) begin
      errors++;
      $display("[TB] FAIL sel3_hold: got tx_hold low during sequence required high throughout");
    end
    @(negedge clk);
    checks++;
    if (cur_sel !== 2'd3) begin
      errors++;
      $display("[TB] FAIL sel3_cur_sel: got %0d required 3", cur_sel);
    end
  endtask

  task automatic test_drain_busy();
    int n;
    tx_busy = 1'b1;
    cfg_req = 1'b1;
    cfg_sel = 2'd0;
    push_seq(tb_div(2'd0));
    @(posedge clk);
    @(negedge clk);
    cfg_req = 1'b0;
    for (int i = 0; i < BUSY_CYC; i++) begin
      checks++;
      if (brg_load_high !== 1'b0 || brg_load_low !== 1'b0 || tx_hold !== 1'b1) begin
        errors++;
        $display("[TB] FAIL drain_hold[%0d]: hi=%b lo=%b hold=%b required 0 0 1", i, brg_load_high, brg_load_low, tx_hold);
      end
      @(negedge clk);
    end
    tx_busy = 1'b0;
    @(negedge clk);
    checks++;
    if (brg_load_high !== 1'b1) begin
      errors++;
      $display("[TB] FAIL drain_release: load_high=%b required 1 one cycle after tx_busy falls", brg_load_high);
    end
    wait_ack(40, n);
    @(negedge clk);
    checks++;
    if (cur_sel !== 2'd0) begin
      errors++;
      $display("[TB] FAIL drain_cur_sel: got %0d required 0", cur_sel);
    end
  endtask

  task automatic test_pending();
    int n;
    int base;
    base = ack_count;
    cfg_req = 1'b1;
    cfg_sel = 2'd1;
    push_seq(tb_div(2'd1));
    @(posedge clk);
    @(negedge clk);
    cfg_req = 1'b0;
    n = 0;
    while (brg_load_low !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    cfg_req = 1'b1;
    cfg_sel = 2'd0;
    @(negedge clk);
    cfg_sel = 2'd2;
    push_seq(tb_div(2'd2));
    @(negedge clk);
    cfg_req = 1'b0;
    wait_ack(40, n);
    checks++;
    if (cfg_ack !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pending_first_ack: got ack=%b after %0d cycles required 1", cfg_ack, n);
    end
    wait_ack(40, n);
    checks++;
    if (cfg_ack !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pending_second_ack: got ack=%b after %0d cycles required 1", cfg_ack, n);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (ack_count - base != 2 || cfg_busy !== 1'b0 || exp_q.size() != 0 || cur_sel !== 2'd2) begin
      errors++;
      $display("[TB] FAIL pending_result: acks=%0d busy=%b queued=%0d sel=%0d required 2 0 0 2",
               ack_count - base, cfg_busy, exp_q.size(), cur_sel);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    cfg_req = 1'b1;
    cfg_sel = 2'd1;
    push_seq(tb_div(2'd1));
    @(posedge clk);
    @(negedge clk);
    cfg_req = 1'b0;
    wait_ack(40, n);
    // Request lands in the DONE cycle itself.
    cfg_req = 1'b1;
    cfg_sel = 2'd3;
    push_seq(tb_div(2'd3));
    @(negedge clk);
    cfg_req = 1'b0;
    checks++;
    if (cfg_busy !== 1'b1 || cfg_ack !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_no_idle: busy=%b ack=%b required 1 0", cfg_busy, cfg_ack);
    end
    @(negedge clk);
    checks++;
    if (brg_load_high !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_load_high: got %b required 1", brg_load_high);
    end
    wait_ack(40, n);
    @(negedge clk);
    checks++;
    if (cur_sel !== 2'd3) begin
      errors++;
      $display("[TB] FAIL b2b_cur_sel: got %0d required 3", cur_sel);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    cfg_req = 1'b1;
    cfg_sel = 2'd3;
    push_hi_lo(tb_div(2'd3));
    @(posedge clk);
    @(negedge clk);
    cfg_req = 1'b0;
    n = 0;
    while (brg_load_low !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (brg_load_high !== 1'b0 || brg_load_low !== 1'b0 || brg_data !== 8'h00 || tx_hold !== 1'b1 ||
        cur_sel !== 2'd1 || brg_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort: hi=%b lo=%b data=%02h hold=%b sel=%0d valid=%b required 0 0 00 1 1 0",
               brg_load_high, brg_load_low, brg_data, tx_hold, cur_sel, brg_valid);
    end
    push_seq(tb_div(2'd1));
    @(negedge clk);
    rst = 1'b0;
    wait_ack(40, n);
    checks++;
    if (cfg_ack !== 1'b1 || n != 3 + SETTLE_CYC) begin
      errors++;
      $display("[TB] FAIL restart_ack: ack=%b cycles=%0d required ack=1 cycles=%0d", cfg_ack, n, 3 + SETTLE_CYC);
    end
    @(negedge clk);
    checks++;
    if (cur_sel !== 2'd1 || brg_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL restart_state: sel=%0d valid=%b required 1 1", cur_sel, brg_valid);
    end
  endtask

`ifdef BRG_DRAIN_TIMEOUT_EN
  task automatic test_drain_timeout();
    int n;
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL err_before_timeout: got %b required 0", cfg_err);
    end
    tx_busy = 1'b1;
    cfg_req = 1'b1;
    cfg_sel = 2'd2;
    push_seq(tb_div(2'd2));
    @(posedge clk);
    @(negedge clk);
    cfg_req = 1'b0;
    n = 1;
    while (brg_load_high !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (brg_load_high !== 1'b1 || n != DRAIN_MAX + 1) begin
      errors++;
      $display("[TB] FAIL timeout_cycles: hi=%b drain_cycles=%0d required hi=1 drain_cycles=%0d",
               brg_load_high, n - 1, DRAIN_MAX);
    end
    checks++;
    if (cfg_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL timeout_err: got %b required 1", cfg_err);
    end
    wait_ack(40, n);
    tx_busy = 1'b0;
    cfg_req = 1'b1;
    cfg_sel = 2'd1;
    push_seq(tb_div(2'd1));
    @(negedge clk);
    cfg_req = 1'b0;
    wait_ack(40, n);
    @(negedge clk);
    checks++;
    if (cfg_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL err_sticky: got %b required 1", cfg_err);
    end
  endtask
`endif

  initial begin
    rst     = 1'b1;
    cfg_req = 1'b0;
    cfg_sel = 2'd0;
    tx_busy = 1'b0;
    test_reset();
    test_sel3();
    test_drain_busy();
    test_pending();
    test_back_to_back();
    test_reset_mid();
`ifdef BRG_DRAIN_TIMEOUT_EN
    test_drain_timeout();
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL leftover_events: got %0d queued required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
